motor_cmd_seq: RTL

MOTOR_CMD_SEQ -- requirements
Module: motor_cmd_seq

---
 rtl/motor_cmd_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_seq.sv
// Stepper move-command sequencer: queues {dir, pulses} moves, issues them to
// the driver one at a time, supervises the busy handshake and tracks position.
`timescale 1ns/1ps
module motor_cmd_seq #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [15:0] START_TIMEOUT = 16'd1000
) (
    input  logic        i_clk_100k,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    input  logic        i_cmd_dir,
    input  logic [23:0] i_cmd_pulses,
    output logic        o_cmd_ready,
    input  logic        i_abort,
    input  logic        i_err_clr,
    output logic        o_start,
    output logic        o_dir,
    output logic [23:0] o_pulses,
    input  logic        i_busy,
    output logic        o_drv_rst,
    output logic        o_done,
    output logic        o_err,
    output logic [4:0]  o_level,
    output logic [31:0] o_position
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_ABORT
    } state_t;

    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;

    state_t        state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic          dir_q, dir_d;
    logic [23:0]   pulses_q, pulses_d;
    logic [31:0]   position_q, position_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          drv_rst_q, drv_rst_d;
    logic          abort_cnt_q, abort_cnt_d;
    logic          alive_q;

    logic          push;
    logic          pop;
    logic          full;
    logic          err_set;
    logic          head_dir;
    logic [23:0]   head_pulses;
    logic [31:0]   pulses_ext;

    assign full        = (level_q == 5'(FIFO_DEPTH));
    assign o_cmd_ready = alive_q & ~full & ~i_abort & (state_q != S_ABORT);
    assign push        = i_cmd_valid & o_cmd_ready;
    assign {head_dir, head_pulses} = fifo_mem[rd_ptr_q];
    assign pulses_ext  = {8'd0, pulses_q};

    always_ff @(posedge i_clk_100k) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {i_cmd_dir, i_cmd_pulses};
        end
    end

    // Abort flushes the queue outright; a push offered during abort never handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = 5'd0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + {4'd0, push} - {4'd0, pop};
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        dir_d       = dir_q;
        pulses_d    = pulses_q;
        position_d  = position_q;
        abort_cnt_d = abort_cnt_q;
        done_d      = 1'b0;
        err_set     = 1'b0;
        pop         = 1'b0;
        if (i_abort) begin
            state_d     = S_ABORT;
            abort_cnt_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (level_q != 5'd0) begin
                        pop = 1'b1;
                        // Zero-length moves complete in place; the driver outputs keep the last issue.
                        if (head_pulses == 24'd0) begin
                            done_d = 1'b1;
                        end else begin
                            dir_d    = head_dir;
                            pulses_d = head_pulses;
                            state_d  = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_d = 16'd0;
                    state_d = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // The o_start cycle accounts for one count, so o_err rises
                    // START_TIMEOUT cycles after the strobe.
                    timer_d = timer_q + 16'd1;
                    if (i_busy) begin
                        state_d = S_WAIT_DONE;
                    end else if (timer_d == START_TIMEOUT - 16'd1) begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_busy) begin
                        position_d = dir_q ? (position_q + pulses_ext) : (position_q - pulses_ext);
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                S_ABORT: begin
                    if (abort_cnt_q) begin
                        state_d = S_IDLE;
                    end else begin
                        abort_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (i_err_clr) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
        drv_rst_d = (state_d == S_ABORT);
    end

    always_ff @(posedge i_clk_100k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 5'd0;
            timer_q     <= 16'd0;
            dir_q       <= 1'b0;
            pulses_q    <= 24'd0;
            position_q  <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            drv_rst_q   <= 1'b1;
            abort_cnt_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            timer_q     <= timer_d;
            dir_q       <= dir_d;
            pulses_q    <= pulses_d;
            position_q  <= position_d;
            done_q      <= done_d;
            err_q       <= err_d;
            drv_rst_q   <= drv_rst_d;
            abort_cnt_q <= abort_cnt_d;
            alive_q     <= 1'b1;
        end
    end

    assign o_start    = (state_q == S_ISSUE);
    assign o_dir      = dir_q;
    assign o_pulses   = pulses_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_drv_rst  = drv_rst_q;
    assign o_level    = level_q;
    assign o_position = position_q;

endmodule
